// File: rtl/lcd_text_fetch.sv
// Text-mode fetch pipeline: pixel coords -> VRAM char -> font row -> RGB565.
// Fixed 4-clock latency with matched DE/HS/VS and a blinking block cursor.
module lcd_text_fetch #(
  parameter int          COLS         = 60,
  parameter int          ROWS         = 34,
  parameter logic [15:0] FG_COLOR     = 16'hFFFF,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [12:0] cursor_addr,
  input  logic        cursor_en,
  output logic [12:0] vram_adb,
  output logic        vram_ceb,
  input  logic [7:0]  vram_dout,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs
);

  localparam int CW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]    COLS_W  = 7'(COLS);
  localparam logic [6:0]    ROWS_W  = 7'(ROWS);
  localparam logic [12:0]   COLS_A  = 13'(COLS);
  localparam logic [12:0]   NCELL   = 13'(COLS * ROWS);
  localparam logic [CW-1:0] BLK_TOP = CW'(BLINK_FRAMES - 1);

  // Side-band bundle carried alongside the fetch
  typedef struct packed {
    logic       in_range;
    logic [2:0] x3;
    logic       hit;
    logic       de;
    logic       hs;
    logic       vs;
  } sb_t;

  logic [6:0]  col;
  logic [6:0]  row;
  logic [12:0] cell_addr;
  logic        in_range;
  logic        hit;

  logic [12:0] adb_q, adb_d;
  logic        ceb_q;
  logic [2:0]  y3_q;
  sb_t         sb1_q, sb1_d;
  sb_t         sb2_q;
  sb_t         sb3_q;
  logic [10:0] fa_q;
  logic [7:0]  glyph_q;

  logic [15:0] rgb_q, rgb_d;
  logic        de_q;
  logic        hs_q;
  logic        vs_q;

  logic          vs_prev_q;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          vs_rise;

  logic [2:0]  bit_idx;
  logic        pix_bit;
  logic        pixel_on;

  assign col       = pix_x[9:3];
  assign row       = pix_y[9:3];
  assign cell_addr = 13'(row) * COLS_A + 13'(col);
  assign in_range  = de_in && (col < COLS_W) && (row < ROWS_W);

  // Cursor can only match a real on-screen cell
  assign hit = in_range
            && (cursor_addr < NCELL)
            && (cell_addr == cursor_addr);

  // Stage-1 next state: address holds when no fetch is issued
  always_comb begin
    adb_d = adb_q;
    if (in_range) adb_d = cell_addr;
    sb1_d = '{
      in_range: in_range,
      x3:       pix_x[2:0],
      hit:      hit,
      de:       de_in,
      hs:       hs_in,
      vs:       vs_in
    };
  end

  // Stage 1: issue VRAM read and capture side-band
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adb_q <= '0;
      ceb_q <= 1'b0;
      y3_q  <= '0;
      sb1_q <= '0;
    end else begin
      adb_q <= adb_d;
      ceb_q <= in_range;
      y3_q  <= pix_y[2:0];
      sb1_q <= sb1_d;
    end
  end

  // Stage 2: form font ROM address from returned char
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fa_q  <= '0;
      sb2_q <= '0;
    end else begin
      fa_q  <= {vram_dout, y3_q};
      sb2_q <= sb1_q;
    end
  end

  // Stage 3: latch glyph row from the font ROM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glyph_q <= '0;
      sb3_q   <= '0;
    end else begin
      glyph_q <= font_data;
      sb3_q   <= sb2_q;
    end
  end

  // Bit 7 is the leftmost pixel, so index = 7 - x3
  assign bit_idx  = ~sb3_q.x3;
  assign pix_bit  = glyph_q[bit_idx];
  assign pixel_on = pix_bit
                  ^ (sb3_q.hit & cursor_en & phase_q);

  // Stage-4 colour select; DE-low or off-grid is black
  always_comb begin
    rgb_d = 16'h0000;
    if (sb3_q.in_range) begin
      rgb_d = pixel_on ? FG_COLOR : BG_COLOR;
    end
  end

  // Stage 4: register pixel and aligned syncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= sb3_q.de;
      hs_q  <= sb3_q.hs;
      vs_q  <= sb3_q.vs;
    end
  end

  assign vs_rise = vs_in & ~vs_prev_q;

  // Frame counter next state, toggles phase on wrap
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (vs_rise) begin
      if (bcnt_q == BLK_TOP) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end
  end

  // Blink state: count vsync rising edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q <= 1'b0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
    end else begin
      vs_prev_q <= vs_in;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
    end
  end

  assign vram_adb  = adb_q;
  assign vram_ceb  = ceb_q;
  assign font_addr = fa_q;
  assign lcd_r     = rgb_q[15:11];
  assign lcd_g     = rgb_q[10:5];
  assign lcd_b     = rgb_q[4:0];
  assign lcd_de    = de_q;
  assign lcd_hs    = hs_q;
  assign lcd_vs    = vs_q;

endmodule

// File: tb/tb_lcd_text_fetch.sv
// Directed bench for lcd_text_fetch with VRAM and font ROM models.
// Cursor blink uses a 2-frame half-period.
module tb_lcd_text_fetch;

  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        de_in = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic [12:0] cursor_addr = '0;
  logic        cursor_en = 1'b0;
  logic [12:0] vram_adb;
  logic        vram_ceb;
  logic [7:0]  vram_dout;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;

  logic [7:0] vram_mem [8192];
  logic [7:0] font_mem [2048];
  logic [15:0] rgb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign vram_dout = vram_mem[vram_adb];
  assign font_data = font_mem[font_addr];
  assign rgb = {lcd_r, lcd_g, lcd_b};

  lcd_text_fetch #(.BLINK_FRAMES(2)) dut (
    .clk(clk),
    .reset(reset),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .de_in(de_in),
    .hs_in(hs_in),
    .vs_in(vs_in),
    .cursor_addr(cursor_addr),
    .cursor_en(cursor_en),
    .vram_adb(vram_adb),
    .vram_ceb(vram_ceb),
    .vram_dout(vram_dout),
    .font_addr(font_addr),
    .font_data(font_data),
    .lcd_r(lcd_r),
    .lcd_g(lcd_g),
    .lcd_b(lcd_b),
    .lcd_de(lcd_de),
    .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y,
                       input logic de, input logic hs,
                       input logic vs);
    pix_x = x;
    pix_y = y;
    de_in = de;
    hs_in = hs;
    vs_in = vs;
  endtask

  task automatic idle();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [43:0] all;
    step();
    step();
    all = {vram_adb, vram_ceb, font_addr, rgb,
           lcd_de, lcd_hs, lcd_vs};
    checks++;
    if (all !== 44'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all);
    end
    reset = 1'b0;
  endtask

  task automatic test_glyph();
    logic [15:0] e [8] = '{BG, BG, FG, FG, FG, FG, BG, BG};
    for (int j = 0; j < 11; j++) begin
      if (j < 8) drive(10'(8 + j), 10'd10, 1'b1, 1'b0, 1'b0);
      else idle();
      step();
      if (j == 0) begin
        checks++;
        if (vram_adb !== 13'd61 || vram_ceb !== 1'b1) begin
          failures++;
          $display("FAIL glyph_adb got=%0d ceb=%b exp=61 ceb=1",
                   vram_adb, vram_ceb);
        end
      end
      if (j == 1) begin
        checks++;
        if (font_addr !== 11'h20A) begin
          failures++;
          $display("FAIL glyph_font_addr got=%h exp=20a", font_addr);
        end
      end
      if (j >= 3) begin
        checks++;
        if (rgb !== e[j-3] || lcd_de !== 1'b1) begin
          failures++;
          $display("FAIL glyph_px[%0d] got=%h de=%b exp=%h de=1",
                   j - 3, rgb, lcd_de, e[j-3]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [43:0] all;
    for (int j = 0; j < 5; j++) begin
      drive(10'(8 + j), 10'd10, 1'b1, 1'b1, 1'b0);
      step();
    end
    checks++;
    if (lcd_de !== 1'b1 || lcd_hs !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got de=%b hs=%b exp 1 1",
               lcd_de, lcd_hs);
    end
    #2;
    reset = 1'b1;
    #1;
    all = {vram_adb, vram_ceb, font_addr, rgb,
           lcd_de, lcd_hs, lcd_vs};
    checks++;
    if (all !== 44'd0) begin
      failures++;
      $display("FAIL midreset_async got=%h exp=0", all);
    end
    idle();
    step();
    reset = 1'b0;
    drive(10'd8, 10'd10, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      step();
      checks++;
      if (lcd_de !== (j >= 3)) begin
        failures++;
        $display("FAIL midreset_de_lat[%0d] got=%b exp=%b",
                 j, lcd_de, (j >= 3));
      end
    end
    idle();
    for (int j = 0; j < 4; j++) step();
  endtask

  task automatic test_out_of_range();
    logic [9:0]  vx [4] = '{10'd479, 10'd480, 10'd0, 10'd479};
    logic [9:0]  vy [4] = '{10'd271, 10'd271, 10'd272, 10'd271};
    logic        vd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] er [4] = '{FG, 16'h0, 16'h0, 16'h0};
    logic        ce [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive(vx[j], vy[j], vd[j], 1'b0, 1'b0);
      else idle();
      step();
      if (j < 4) begin
        checks++;
        if (vram_adb !== 13'd2039 || vram_ceb !== ce[j]) begin
          failures++;
          $display("FAIL oor_fetch[%0d] got adb=%0d ceb=%b exp adb=2039 ceb=%b",
                   j, vram_adb, vram_ceb, ce[j]);
        end
      end
      if (j >= 3) begin
        checks++;
        if (rgb !== er[j-3] || lcd_de !== vd[j-3]) begin
          failures++;
          $display("FAIL oor_px[%0d] got=%h de=%b exp=%h de=%b",
                   j - 3, rgb, lcd_de, er[j-3], vd[j-3]);
        end
      end
    end
  endtask

  task automatic test_blink();
    int         np [5] = '{0, 2, 2, 2, 0};
    logic       en [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int         xb [5] = '{8, 8, 8, 8, 16};
    logic [7:0] pt [5] = '{8'h3C, 8'hC3, 8'h3C, 8'h3C, 8'h00};
    logic [7:0] cur;
    logic [15:0] ex;
    cursor_addr = 13'd61;
    for (int p = 0; p < 5; p++) begin
      cursor_en = en[p];
      cur = pt[p];
      for (int k = 0; k < np[p]; k++) begin
        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        step();
        step();
      end
      for (int j = 0; j < 11; j++) begin
        if (j < 8) drive(10'(xb[p] + j), 10'd10, 1'b1, 1'b0, 1'b0);
        else idle();
        step();
        if (j >= 3) begin
          ex = cur[3'(10 - j)] ? FG : BG;
          checks++;
          if (rgb !== ex) begin
            failures++;
            $display("FAIL blink_p%0d_px[%0d] got=%h exp=%h",
                     p, j - 3, rgb, ex);
          end
        end
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_sync();
    logic hv [10] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    logic vv [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
    logic dv [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    for (int j = 0; j < 13; j++) begin
      if (j < 10) drive(10'd600, 10'd0, dv[j], hv[j], vv[j]);
      else idle();
      step();
      if (j >= 3) begin
        checks++;
        if (lcd_hs !== hv[j-3] || lcd_vs !== vv[j-3] ||
            lcd_de !== dv[j-3] || rgb !== 16'h0) begin
          failures++;
          $display("FAIL sync[%0d] got hs=%b vs=%b de=%b rgb=%h exp hs=%b vs=%b de=%b rgb=0",
                   j - 3, lcd_hs, lcd_vs, lcd_de, rgb,
                   hv[j-3], vv[j-3], dv[j-3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e [3] = '{BG, FG, BG};
    cursor_en = 1'b0;
    for (int j = 0; j < 27; j++) begin
      if (j < 24) drive(10'(24 + j), 10'd10, 1'b1, 1'b0, 1'b0);
      else idle();
      step();
      if (j >= 3) begin
        checks++;
        if (rgb !== e[(j-3)/8]) begin
          failures++;
          $display("FAIL b2b_px[%0d] got=%h exp=%h",
                   j - 3, rgb, e[(j-3)/8]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vram_mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
    vram_mem[61]   = 8'h41;
    vram_mem[64]   = 8'hFF;
    vram_mem[2039] = 8'hFF;
    font_mem[11'h20A] = 8'h3C;
    for (int r = 0; r < 8; r++) font_mem[11'h7F8 + r] = 8'hFF;

    test_reset();
    test_glyph();
    test_reset_midframe();
    test_out_of_range();
    test_blink();
    test_sync();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
